// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: counts in-flight writers per architectural
// register between issue and writeback and raises the decode stall.
module id_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int CNT_W = 2,
  parameter int TOT_W = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 is_valid,
  input  logic                 is_go,
  input  logic                 is_we,
  input  logic [AW-1:0]        is_waddr,
  input  logic [NSRC*AW-1:0]   is_src_addr,
  input  logic [NSRC-1:0]      is_src_need,
  input  logic [NSRC-1:0]      is_src_fwd,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_waddr,
  output logic [NSRC-1:0]      src_busy,
  output logic                 sb_full,
  output logic                 ds_stall,
  output logic [TOT_W-1:0]     inflight,
  output logic                 sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             err_q, err_d;

  logic src_stall;
  logic issue_try;
  logic retire;
  logic same_reg;
  logic full_bypass;
  logic issue_ok;
  logic retire_ok;
  logic go_err;
  logic under_err;

  // Source lookups read pre-retire state; r0 is never busy.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic [AW-1:0] addr;
    assign addr         = is_src_addr[gi*AW +: AW];
    assign src_busy[gi] = resetn && (addr != '0) && (cnt_q[addr] != '0);
  end

  always_comb begin
    src_stall = |(src_busy & is_src_need & ~is_src_fwd);
    sb_full   = resetn && is_we && (is_waddr != '0) && (cnt_q[is_waddr] == CNT_MAX);
    ds_stall  = is_valid && (src_stall || sb_full);

    issue_try = is_valid && is_go && is_we && (is_waddr != '0);
    retire    = wb_valid && (wb_waddr != '0);
    same_reg  = (is_waddr == wb_waddr);

    // A saturated register retiring in the same cycle frees the slot the issue
    // reuses, so that pairing is accepted despite the stall and nets to zero.
    full_bypass = issue_try && retire && same_reg && sb_full && !src_stall;
    issue_ok    = issue_try && (!ds_stall || full_bypass);
    go_err      = is_valid && is_go && ds_stall && !full_bypass;
    under_err   = retire && (cnt_q[wb_waddr] == '0) && !(issue_ok && same_reg);
    retire_ok   = retire && !under_err;

    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0) begin
        if (issue_ok && (is_waddr == AW'(r)) && !(retire_ok && (wb_waddr == AW'(r))))
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
        else if (retire_ok && (wb_waddr == AW'(r)) && !(issue_ok && (is_waddr == AW'(r))))
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end

    tot_d = tot_q + TOT_W'(issue_ok) - TOT_W'(retire_ok);
    err_d = err_q || go_err || under_err;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      tot_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      tot_q <= tot_d;
      err_q <= err_d;
    end
  end

  assign inflight = tot_q;
  assign sb_err   = err_q;

endmodule
